// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : shared pipeline constants, skid-buffer state encoding, helpers
// Revision : 1.0
// ============================================================================
package pipe_pkg;

  localparam int MIN_NUM_IN = 2;
  localparam int MAX_NUM_IN = 16;

  // Skid-buffer occupancy: m holds the output beat, s the overflow beat.
  localparam logic [1:0] c_st_empty = 2'd0;
  localparam logic [1:0] c_st_one   = 2'd1;
  localparam logic [1:0] c_st_full  = 2'd2;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skid_buf.sv
`default_nettype none
// ============================================================================
// skid_buf : two-entry registered skid buffer with valid/ready and flush
// Revision : 1.0
// ============================================================================
module skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [W-1:0] r_m_data;
  logic [W-1:0] r_s_data;
  logic         w_accept;
  logic         w_consume;
  logic         w_load_m_in;
  logic         w_load_m_skid;
  logic         w_load_s;

  assign w_accept  = in_valid && in_ready;
  assign w_consume = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_empty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load_m_in   = 1'b0;
    w_load_m_skid = 1'b0;
    w_load_s      = 1'b0;
    case (r_state)
      c_st_empty: begin
        if (w_accept) begin
          w_state_nxt = c_st_one;
          w_load_m_in = 1'b1;
        end
      end
      c_st_one: begin
        if (w_accept && w_consume) begin
          w_load_m_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = c_st_full;
          w_load_s    = 1'b1;
        end else if (w_consume) begin
          w_state_nxt = c_st_empty;
        end
      end
      c_st_full: begin
        if (w_consume) begin
          w_state_nxt   = c_st_one;
          w_load_m_skid = 1'b1;
        end
      end
      default: w_state_nxt = c_st_empty;
    endcase
    // Flush only drops occupancy; data registers keep their last contents.
    if (flush) begin
      w_state_nxt   = c_st_empty;
      w_load_m_in   = 1'b0;
      w_load_m_skid = 1'b0;
      w_load_s      = 1'b0;
    end
  end

  always_comb begin
    out_valid = (r_state == c_st_one) || (r_state == c_st_full);
    in_ready  = (r_state != c_st_full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data <= '0;
      r_s_data <= '0;
    end else begin
      if (w_load_m_in) begin
        r_m_data <= in_data;
      end else if (w_load_m_skid) begin
        r_m_data <= r_s_data;
      end
      if (w_load_s) begin
        r_s_data <= in_data;
      end
    end
  end

  assign out_data = r_m_data;

endmodule
`default_nettype wire

// File: rtl/sel_pipe_stage.sv
`default_nettype none
// ============================================================================
// sel_pipe_stage : N-way operand select feeding a registered skid stage
// Revision : 1.0
// ============================================================================
module sel_pipe_stage
  import pipe_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 6,
  localparam int SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    sel_err
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  beat_t w_in_beat;
  beat_t w_out_beat;

  generate
    if (NUM_IN < MIN_NUM_IN || NUM_IN > MAX_NUM_IN) begin : g_num_in_check
      $error("sel_pipe_stage: NUM_IN must be in 2..16");
    end
  endgenerate

  // Out-of-range indices yield a zero word tagged with the error bit.
  always_comb begin
    w_in_beat     = '0;
    w_in_beat.err = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel) == k) begin
        w_in_beat.data = din[k*WIDTH +: WIDTH];
        w_in_beat.err  = 1'b0;
      end
    end
  end

  skid_buf #(
    .W ($bits(beat_t))
  ) u_skid_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_beat),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_beat)
  );

  assign dout    = w_out_beat.data;
  assign sel_err = w_out_beat.err;

endmodule
`default_nettype wire
